// File: rtl/branch_resolve_if.sv
// Handshake and result bundle between the comparator stage, branch_resolve and fetch.
// The master side is whoever offers branches and consumes results; the slave side is branch_resolve.
interface branch_resolve_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             big;
   logic             equal;
   logic             little;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  offset;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic [PC_W-1:0]  target;
   logic             flush;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] taken_cnt;
   logic             flag_err;

   modport master (
      output in_valid, op, big, equal, little, pc, offset, out_ready,
      input  in_ready, out_valid, taken, target, flush, branch_cnt, taken_cnt, flag_err
   );

   modport slave (
      input  in_valid, op, big, equal, little, pc, offset, out_ready,
      output in_ready, out_valid, taken, target, flush, branch_cnt, taken_cnt, flag_err
   );
endinterface

// File: rtl/branch_resolve.sv
// Resolves a branch from comparator flags and opcode, computes the redirect target and holds it
// in a one-entry valid/ready register, with saturating statistics and a sticky flag-error bit.
module branch_resolve #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst,
   branch_resolve_if.slave bus
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e           state_q, state_d;
   logic             taken_q, taken_d;
   logic [PC_W-1:0]  target_q, target_d;
   logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
   logic [CNT_W-1:0] takenCnt_q, takenCnt_d;
   logic             flagErr_q, flagErr_d;

   logic             inReady;
   logic             inFire;
   logic             outFire;
   logic             decTaken;
   logic             flagsOneHot;
   logic [PC_W-1:0]  seqPc;
   logic [PC_W-1:0]  branchPc;

   always_comb begin
      decTaken = 1'b0;
      case (bus.op)
         3'd0:    decTaken = bus.equal;
         3'd1:    decTaken = !bus.equal;
         3'd2:    decTaken = bus.big;
         3'd3:    decTaken = bus.little;
         3'd4:    decTaken = bus.big | bus.equal;
         3'd5:    decTaken = bus.little | bus.equal;
         3'd6:    decTaken = 1'b1;
         default: decTaken = 1'b0;
      endcase
   end

   // Offsets are in words, so both candidate targets wrap modulo 2^PC_W.
   assign seqPc       = bus.pc + PC_W'(4);
   assign branchPc    = seqPc + (bus.offset << 2);
   assign flagsOneHot = ({bus.big, bus.equal, bus.little} == 3'b100) ||
                        ({bus.big, bus.equal, bus.little} == 3'b010) ||
                        ({bus.big, bus.equal, bus.little} == 3'b001);

   // in_ready never looks at in_valid, which keeps the upstream handshake loop-free.
   assign inReady = (state_q == EMPTY) || bus.out_ready;
   assign inFire  = bus.in_valid && inReady;
   assign outFire = (state_q == FULL) && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      taken_d     = taken_q;
      target_d    = target_q;
      branchCnt_d = branchCnt_q;
      takenCnt_d  = takenCnt_q;
      flagErr_d   = flagErr_q;

      case (state_q)
         EMPTY:   if (bus.in_valid) state_d = FULL;
         FULL:    if (bus.out_ready && !bus.in_valid) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (inFire) begin
         taken_d  = decTaken;
         target_d = decTaken ? branchPc : seqPc;
         if (!flagsOneHot) flagErr_d = 1'b1;
      end

      if (outFire) begin
         if (branchCnt_q != '1) branchCnt_d = branchCnt_q + CNT_W'(1);
         if (taken_q && (takenCnt_q != '1)) takenCnt_d = takenCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         taken_q     <= 1'b0;
         target_q    <= '0;
         branchCnt_q <= '0;
         takenCnt_q  <= '0;
         flagErr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         branchCnt_q <= branchCnt_d;
         takenCnt_q  <= takenCnt_d;
         flagErr_q   <= flagErr_d;
      end
   end

   assign bus.in_ready   = inReady;
   assign bus.out_valid  = (state_q == FULL);
   assign bus.taken      = taken_q;
   assign bus.target     = target_q;
   assign bus.flush      = (state_q == FULL) && taken_q;
   assign bus.branch_cnt = branchCnt_q;
   assign bus.taken_cnt  = takenCnt_q;
   assign bus.flag_err   = flagErr_q;

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Pipeline stage directly downstream of the 32-bit unsigned comparator. It takes the comparator's `big`/`equal`/`little` flags together with the branch opcode, PC and offset, decides taken or not-taken, and computes the redirect target. It holds the result in a one-entry valid/ready output register for the fetch/redirect logic. It also keeps saturating branch statistics and a sticky flag-consistency error.

## Interface
Parameters:
- `PC_W`, 32: width of `pc`, `offset` and `target`.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  the single clock; everything updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream offers a branch.
- `in_ready`  out  1  stage can accept this cycle.
- `op`  in  3  branch opcode (encoding below).
- `big`, `equal`, `little`  in  1 each  comparator flags for data1 vs data2, unsigned.
- `pc`  in  PC_W  address of the branch instruction.
- `offset`  in  PC_W  signed word offset, already sign-extended.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `taken`  out  1  branch decision.
- `target`  out  PC_W  next PC.
- `flush`  out  1  equals `out_valid & taken`.
- `branch_cnt`  out  CNT_W  results delivered since reset.
- `taken_cnt`  out  CNT_W  taken results delivered since reset.
- `flag_err`  out  1  sticky error flag.

## Operation
- Opcode decode:
  - 0 BEQ → `equal`
  - 1 BNE → `!equal`
  - 2 BGT → `big`
  - 3 BLT → `little`
  - 4 BGE → `big|equal`
  - 5 BLE → `little|equal`
  - 6 JMP → 1
  - 7 reserved → 0
- Target calculation:
  - Taken: `target = pc + 4 + (offset << 2)`, truncated to PC_W. Wrap-around is modulo 2^PC_W with no overflow flag.
  - Not taken: `target = pc + 4`, also modulo.
- Two-state FSM:
  - EMPTY: `out_valid` = 0, `in_ready` = 1.
  - FULL: `out_valid` = 1, `in_ready` = `out_ready`.
- Transitions:
  - EMPTY→FULL on `in_valid`.
  - FULL→EMPTY on `out_ready & !in_valid`.
  - FULL→FULL with a new result loaded on `out_ready & in_valid`, i.e. simultaneous drain and accept gives back-to-back throughput.
  - FULL→FULL holding on `!out_ready`.
- While FULL and stalled, `taken`/`target` are stable, and inputs are ignored because `in_ready` = 0.
- Counters:
  - `branch_cnt` increments on every output handshake (`out_valid & out_ready`).
  - `taken_cnt` increments on an output handshake when `taken` = 1.
  - Both saturate at all-ones and never wrap.
- `flag_err` sets on an input handshake whose flags are not exactly one-hot. Examples: 000, 011, 111.
  - For JMP and reserved opcodes the flags are still checked.
  - The decision still uses the flags as given.
  - `flag_err` clears only on `rst`.

## Timing
- Latency: an input handshake at edge N gives the result visible (`out_valid` = 1) after edge N; 1 cycle.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `flush` is combinational from registered state.
- Reset values: `out_valid` 0, `taken` 0, `target` 0, `flush` 0, `branch_cnt` 0, `taken_cnt` 0, `flag_err` 0, state EMPTY. `in_ready` = 1 from the first cycle after reset.
- Reset mid-operation: a held result is discarded and not counted. A handshake in the reset cycle is ignored.
- Counter saturation: a handshake while a counter is at all-ones leaves it at all-ones. The other counter still updates.

## Test plan
- BEQ with equal=1, pc=0x0000_1000, offset=0x0000_0003, out_ready=1 → 1 cycle later: `out_valid`=1, `taken`=1, `target`=0x0000_1010, `flush`=1. Next cycle: `branch_cnt`=1, `taken_cnt`=1.
- BLT with big=1, pc=0x0000_2000 → `taken`=0, `target`=0x0000_2004, `flush`=0; after the handshake `taken_cnt` is unchanged.
- Wrap-around: JMP, pc=0xFFFF_FFF8, offset=0x0000_0002 → `target`=0x0000_0004. Negative offset: pc=0x100, offset=0xFFFF_FFFE → `target`=0x0FC.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `target` stable, no counting. Then `out_ready`=1 with `in_valid`=1 → drain and load in the same edge, with one increment per delivered result.
- Flags 011 on BGE → `taken`=1 and `flag_err`=1, staying set through later clean branches until `rst`. Assert `rst` while FULL → next cycle `out_valid`=0, counters 0, `flag_err`=0.
- CNT_W=2: deliver 5 taken branches → `branch_cnt`=3, `taken_cnt`=3.
